muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_defs.sv | 51 +++++
 rtl/muldiv_negate.sv | 12 +
 rtl/muldiv_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/muldiv_defs.sv
// Shared operation and state encodings for the multiply/divide unit and the ALU decoder.
// Helper functions map an operation to its operand signedness and result-sign rule.
package muldiv_defs;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic op_is_high(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

    function automatic logic opd1_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic opd2_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder follows the dividend sign; products and quotients follow the sign product.
    function automatic logic result_neg(input muldiv_op_e op, input logic s1, input logic s2);
        case (op)
            OP_MULH, OP_DIV: return s1 ^ s2;
            OP_MULHSU, OP_REM: return s1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply, restoring divide,
// one step per cycle on magnitudes with a registered sign correction at the end.
module muldiv_unit
    import muldiv_defs::*;
#(
    parameter int OPERAND_LENGTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    input  logic [2:0]                alu_op_select,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OPERAND_LENGTH-1:0] muldiv_result,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int N  = OPERAND_LENGTH;
    localparam int CW = $clog2(N) + 1;
    localparam int AW = 2 * N + 1;

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [N-1:0]    opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [N-1:0]    result_q, result_d;

    // Request decode (only meaningful while idle)
    muldiv_op_e      op_in;
    logic            s1, s2, neg_in, div_by_zero, div_ovf;
    logic [N-1:0]    mag1, mag2;

    assign op_in       = muldiv_op_e'(alu_op_select);
    assign s1          = opd1_signed(op_in) & opd1[N-1];
    assign s2          = opd2_signed(op_in) & opd2[N-1];
    assign neg_in      = result_neg(op_in, s1, s2);
    assign div_by_zero = (opd2 == '0);
    assign div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                         (opd1 == {1'b1, {(N-1){1'b0}}}) && (opd2 == '1);

    muldiv_negate #(.WIDTH(N)) u_mag1 (.val_i(opd1), .neg_i(s1), .res_o(mag1));
    muldiv_negate #(.WIDTH(N)) u_mag2 (.val_i(opd2), .neg_i(s2), .res_o(mag2));

    // Multiply step: acc = {hi(N+1), multiplier(N)}; add multiplicand to hi then shift right.
    logic [N:0]      mul_sum;
    logic [AW-1:0]   mul_step;
    assign mul_sum  = acc_q[AW-1:N] + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    assign mul_step = {1'b0, mul_sum, acc_q[N-1:1]};

    // Divide step: acc = {rem(N+1), dividend/quotient(N)}; shift left, trial-subtract divisor.
    logic [N:0]      rem_hi, rem_trial, rem_new;
    logic            rem_fits;
    logic [AW-1:0]   div_step;
    assign rem_hi    = acc_q[AW-2:N-1];
    assign rem_fits  = (rem_hi >= {1'b0, opnd_q});
    assign rem_trial = rem_hi - {1'b0, opnd_q};
    assign rem_new   = rem_fits ? rem_trial : rem_hi;
    assign div_step  = {rem_new, acc_q[N-2:0], rem_fits};

    logic [AW-1:0]   acc_step;
    assign acc_step = op_is_div(op_q) ? div_step : mul_step;

    // Sign fix-up of the final step, registered on entry to DONE.
    logic [2*N-1:0]  corr_in, corr_out;
    logic [N-1:0]    corr_sel;

    always_comb begin
        corr_in = acc_step[2*N-1:0];
        if (op_is_rem(op_q)) begin
            corr_in = {{N{1'b0}}, acc_step[2*N-1:N]};
        end else if (op_is_div(op_q)) begin
            corr_in = {{N{1'b0}}, acc_step[N-1:0]};
        end
    end

    muldiv_negate #(.WIDTH(2 * N)) u_corr (.val_i(corr_in), .neg_i(neg_q), .res_o(corr_out));

    assign corr_sel = op_is_high(op_q) ? corr_out[2*N-1:N] : corr_out[N-1:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = op_in;
                    neg_d = neg_in;
                    cnt_d = '0;
                    if (op_is_div(op_in) && div_by_zero) begin
                        state_d  = ST_DONE;
                        result_d = op_is_rem(op_in) ? opd1 : '1;
                    end else if (div_ovf) begin
                        state_d  = ST_DONE;
                        result_d = (op_in == OP_DIV) ? opd1 : '0;
                    end else begin
                        state_d = ST_CALC;
                        if (op_is_div(op_in)) begin
                            opnd_d = mag2;
                            acc_d  = {{(N+1){1'b0}}, mag1};
                        end else begin
                            opnd_d = mag1;
                            acc_d  = {{(N+1){1'b0}}, mag2};
                        end
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = ST_DONE;
                    result_d = corr_sel;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_DONE);
    assign muldiv_result = result_q;

endmodule
